cal_date_engine: RTL and testbench
==================================

CAL_DATE_ENGINE -- requirements
Module: cal_date_engine

Interface
REQ-001 Parameter YEAR_W, default 16: width of the year field; legal range 12..24.
REQ-002 Parameter RST_YEAR, default 2000: year loaded at reset; date 01-01 of that year.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 load_valid  in  1  request to load load_year/load_month/load_day.
REQ-007 load_ready  out  1  equals !busy.
REQ-008 load_year  in  YEAR_W  year to load.
REQ-009 load_month  in  4  month to load, 1..12.
REQ-010 load_day  in  5  day to load, 1..31.
REQ-011 tick_up  in  1  advance one day.
REQ-012 tick_dn  in  1  retreat one day.
REQ-013 year  out  YEAR_W  current year.
REQ-014 month  out  4  current month.
REQ-015 day  out  5  current day.
REQ-016 week  out  3  weekday; 0=Sunday .. 6=Saturday.
REQ-017 week_valid  out  1  week matches the current date.
REQ-018 busy  out  1  weekday computation in progress.
REQ-019 load_err  out  1  one-cycle pulse: accepted load was an invalid date.
REQ-020 ovf  out  1  one-cycle pulse: tick refused at the calendar limit.
REQ-021 tick_drop  out  1  one-cycle pulse: tick ignored because busy or load took priority.

Function
REQ-022 States IDLE, DIV, SUM, MOD; busy=1 in every state except IDLE.
REQ-023 Load is accepted on an edge where load_valid && load_ready.
- Valid date: year/month/day update on that edge; week_valid=0; go to DIV.
- Invalid date: load_err pulses; no state change.
REQ-024 Valid date: year>=1, month 1..12, 1<=day<=days-in-month, Gregorian leap rule (div 4 and not div 100, or div 400).
REQ-025 Weekday computation uses Zeller's rule with non-negative terms.
- Jan and Feb: m=month+12, y=year-1; otherwise m=month, y=year.
- k=y%100, j=y/100.
- S=day+floor(13(m+1)/5)+k+k/4+j/4+5j+6; week=S%7.
REQ-026 Datapath stages:
- DIV: y/100 by restoring division, one bit per cycle, YEAR_W cycles.
- SUM: one cycle.
- MOD: S%7 by restoring reduction over YEAR_W+4 cycles.
REQ-027 Latency L=2*YEAR_W+6 edges (38 at default). With the acceptance edge as edge 0, at edge L: week updates, week_valid=1, busy=0, state=IDLE.
REQ-028 In IDLE with week_valid=1, tick_up alone SHALL:
- advance the date, handling month-end, Feb 28/29 and year rollover;
- set week=(week+1)%7 on the same edge.
REQ-029 tick_dn alone SHALL retreat the date symmetrically and set week=(week+6)%7.
REQ-030 tick_up && tick_dn together: no change and no pulse.
REQ-031 Tick on an edge where busy=1 or a load is accepted: no date change; tick_drop pulses.
REQ-032 Calendar limits:
- tick_up at (2^YEAR_W-1)-12-31: date held, ovf pulses.
- tick_dn at 0001-01-01: date held, ovf pulses.
REQ-033 load_err, ovf and tick_drop SHALL be single-cycle pulses registered on the causing edge.

Reset
REQ-034 While rst_n=0, outputs SHALL be:
- year=RST_YEAR, month=1, day=1;
- week=0, week_valid=0;
- busy=1, state=DIV;
- load_err=0, ovf=0, tick_drop=0.
REQ-035 The first rising edge with rst_n=1 SHALL count as edge 0 of a computation for the reset date, completing per REQ-027.
REQ-036 Reset asserted mid-computation SHALL abort it and restart per REQ-034/035.

Verification
REQ-037 Reset release, defaults -> busy=1 for 38 edges; then busy=0, week=6 (2000-01-01 Saturday), week_valid=1.
REQ-038 Load 2024-02-28, wait 38, then tick_up x2:
- after load: week=3;
- after 1st tick: 2024-02-29, week=4;
- after 2nd tick: 2024-03-01, week=5.
REQ-039 Load 1900-02-28, wait 38, then tick_up -> 1900-03-01, week=4; 1900 is not leap.
REQ-040 Load 2023-02-29 -> load_err=1 for one cycle; date and week unchanged; busy stays 0.
REQ-041 Load 0001-01-01, wait 38 -> week=1; then tick_dn -> ovf=1 for one cycle, date unchanged.
REQ-042 Tick collisions:
- load_valid and tick_up on the same idle edge -> load accepted, tick_drop=1.
- tick_up during busy -> tick_drop=1, date unchanged.

Source files
------------

// File: rtl/cal_date_engine.sv
// rtl/cal_date_engine.sv - calendar date register with day ticks and serial Zeller weekday engine
module cal_date_engine #(
    parameter int YEAR_W   = 16,
    parameter int RST_YEAR = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [3:0]        load_month,
    input  logic [4:0]        load_day,
    input  logic              tick_up,
    input  logic              tick_dn,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        month,
    output logic [4:0]        day,
    output logic [2:0]        week,
    output logic              week_valid,
    output logic              busy,
    output logic              load_err,
    output logic              ovf,
    output logic              tick_drop
);
    typedef enum logic [1:0] {IDLE, DIV, SUM, MOD} state_t;

    localparam int CW = 6;
    localparam int SW = YEAR_W + 4;
    localparam logic [YEAR_W-1:0] RST_Y = YEAR_W'(RST_YEAR);
    localparam logic [YEAR_W-1:0] MAX_Y = '1;
    localparam logic [YEAR_W-1:0] ONE_Y = YEAR_W'(1);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return ((y[1:0] == 2'd0) && ((y % YEAR_W'(100)) != '0)) || ((y % YEAR_W'(400)) == '0);
    endfunction

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic [YEAR_W-1:0] y);
        case (m)
            4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              start_q, start_d;
    logic [6:0]        rem_q, rem_d;
    logic [YEAR_W-1:0] quot_q, quot_d;
    logic [SW-1:0]     s_q, s_d;
    logic [2:0]        md_q, md_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        month_q, month_d;
    logic [4:0]        day_q, day_d;
    logic [2:0]        week_q, week_d;
    logic              week_valid_q, week_valid_d;
    logic              load_err_q, load_err_d;
    logic              ovf_q, ovf_d;
    logic              tick_drop_q, tick_drop_d;

    logic              is_busy;
    logic              tick_one;
    logic              load_ok;
    logic [YEAR_W-1:0] y_cur;
    logic [YEAR_W-1:0] y_sh;
    logic [7:0]        m_z;
    logic [7:0]        t13;
    logic [7:0]        rx;
    logic [3:0]        mx;

    assign is_busy    = (state_q != IDLE);
    assign busy       = is_busy;
    assign load_ready = !is_busy;
    assign year       = year_q;
    assign month      = month_q;
    assign day        = day_q;
    assign week       = week_q;
    assign week_valid = week_valid_q;
    assign load_err   = load_err_q;
    assign ovf        = ovf_q;
    assign tick_drop  = tick_drop_q;

    // Zeller operands derived from the held date: Jan/Feb count as months 13/14 of the previous year
    always_comb begin
        y_cur    = (month_q <= 4'd2) ? (year_q - ONE_Y) : year_q;
        m_z      = (month_q <= 4'd2) ? ({4'd0, month_q} + 8'd12) : {4'd0, month_q};
        t13      = (8'd13 * (m_z + 8'd1)) / 8'd5;
        tick_one = tick_up ^ tick_dn;
        load_ok  = (load_year != '0) && (load_month >= 4'd1) && (load_month <= 4'd12) &&
                   (load_day >= 5'd1) && (load_day <= days_in(load_month, load_year));
    end

    // Next-state: load/tick handling in IDLE, otherwise one step of the weekday datapath
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        s_d          = s_q;
        md_d         = md_q;
        year_d       = year_q;
        month_d      = month_q;
        day_d        = day_q;
        week_d       = week_q;
        week_valid_d = week_valid_q;
        load_err_d   = 1'b0;
        ovf_d        = 1'b0;
        tick_drop_d  = 1'b0;
        y_sh         = '0;
        rx           = '0;
        mx           = '0;

        if (is_busy && tick_one) begin
            tick_drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    if (tick_one) begin
                        tick_drop_d = 1'b1;
                    end
                    if (load_ok) begin
                        year_d       = load_year;
                        month_d      = load_month;
                        day_d        = load_day;
                        week_valid_d = 1'b0;
                        state_d      = DIV;
                        cnt_d        = '0;
                        start_d      = 1'b0;
                        rem_d        = '0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (tick_up && !tick_dn) begin
                    if (day_q < days_in(month_q, year_q)) begin
                        day_d = day_q + 5'd1;
                    end else if (month_q != 4'd12) begin
                        month_d = month_q + 4'd1;
                        day_d   = 5'd1;
                    end else if (year_q != MAX_Y) begin
                        year_d  = year_q + ONE_Y;
                        month_d = 4'd1;
                        day_d   = 5'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (!ovf_d) begin
                        week_d = (week_q == 3'd6) ? 3'd0 : (week_q + 3'd1);
                    end
                end else if (tick_dn && !tick_up) begin
                    if (day_q > 5'd1) begin
                        day_d = day_q - 5'd1;
                    end else if (month_q > 4'd1) begin
                        month_d = month_q - 4'd1;
                        day_d   = days_in(month_q - 4'd1, year_q);
                    end else if (year_q != ONE_Y) begin
                        year_d  = year_q - ONE_Y;
                        month_d = 4'd12;
                        day_d   = 5'd31;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (!ovf_d) begin
                        week_d = (week_q == 3'd0) ? 3'd6 : (week_q - 3'd1);
                    end
                end
            end
            DIV: begin
                // The first edge out of reset only arms the divider so reset and load share one latency
                if (start_q) begin
                    start_d = 1'b0;
                    rem_d   = '0;
                end else begin
                    y_sh = y_cur << cnt_q;
                    rx   = {rem_q, y_sh[YEAR_W-1]};
                    if (rx >= 8'd100) begin
                        rx = rx - 8'd100;
                    end
                    rem_d  = rx[6:0];
                    quot_d = {quot_q[YEAR_W-2:0], (rx != {rem_q, y_sh[YEAR_W-1]})};
                    if (cnt_q == CW'(YEAR_W - 1)) begin
                        state_d = SUM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SUM: begin
                s_d = SW'(day_q) + SW'(t13) + SW'(rem_q) + SW'(rem_q[6:2]) +
                      SW'(quot_q[YEAR_W-1:2]) + (SW'(quot_q) << 2) + SW'(quot_q) + SW'(6);
                md_d    = '0;
                cnt_d   = '0;
                state_d = MOD;
            end
            MOD: begin
                // SW reduction steps, then one extra edge commits the weekday
                if (cnt_q == CW'(SW)) begin
                    week_d       = md_q;
                    week_valid_d = 1'b1;
                    state_d      = IDLE;
                    cnt_d        = '0;
                end else begin
                    mx = {md_q, s_q[SW-1]};
                    if (mx >= 4'd7) begin
                        mx = mx - 4'd7;
                    end
                    md_d  = mx[2:0];
                    s_d   = s_q << 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset parks the engine at the start of a weekday computation for RST_YEAR-01-01
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DIV;
            cnt_q        <= '0;
            start_q      <= 1'b1;
            rem_q        <= '0;
            quot_q       <= '0;
            s_q          <= '0;
            md_q         <= '0;
            year_q       <= RST_Y;
            month_q      <= 4'd1;
            day_q        <= 5'd1;
            week_q       <= 3'd0;
            week_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
            ovf_q        <= 1'b0;
            tick_drop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            s_q          <= s_d;
            md_q         <= md_d;
            year_q       <= year_d;
            month_q      <= month_d;
            day_q        <= day_d;
            week_q       <= week_d;
            week_valid_q <= week_valid_d;
            load_err_q   <= load_err_d;
            ovf_q        <= ovf_d;
            tick_drop_q  <= tick_drop_d;
        end
    end
endmodule

// File: tb/tb_cal_date_engine.sv
// tb/tb_cal_date_engine.sv - self-checking bench for cal_date_engine
module tb_cal_date_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_year;
    logic [3:0]  load_month;
    logic [4:0]  load_day;
    logic        tick_up;
    logic        tick_dn;
    logic [15:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [2:0]  week;
    logic        week_valid;
    logic        busy;
    logic        load_err;
    logic        ovf;
    logic        tick_drop;

    always #5 clk = ~clk;

    cal_date_engine dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_year(load_year), .load_month(load_month), .load_day(load_day),
        .tick_up(tick_up), .tick_dn(tick_dn), .year(year), .month(month), .day(day),
        .week(week), .week_valid(week_valid), .busy(busy), .load_err(load_err),
        .ovf(ovf), .tick_drop(tick_drop)
    );

    typedef struct {
        int y; int m; int d; bit err; int wk;
        int tk; int ny; int nm; int nd; int nwk; bit ovf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_y, cur_m, cur_d, cur_w;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic bit m_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int m_dim(input int y, input int m);
        int t[12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && m_leap(y)) return 29;
        return t[m-1];
    endfunction

    // Weekday from the day count since 0001-01-01 (a Monday)
    function automatic int m_wday(input int y, input int m, input int d);
        longint n;
        n = 365 * longint'(y - 1) + (y - 1) / 4 - (y - 1) / 100 + (y - 1) / 400;
        for (int mm = 1; mm < m; mm++) n += m_dim(y, mm);
        n += d - 1;
        return int'((n + 1) % 7);
    endfunction

    task automatic m_step(input int y, input int m, input int d, input int dir,
                          output int ny, output int nm, output int nd, output bit ov);
        ov = 1'b0; ny = y; nm = m; nd = d;
        if (dir == 1) begin
            if (y == 65535 && m == 12 && d == 31) ov = 1'b1;
            else if (d < m_dim(y, m)) nd = d + 1;
            else if (m < 12) begin nm = m + 1; nd = 1; end
            else begin ny = y + 1; nm = 1; nd = 1; end
        end else begin
            if (y == 1 && m == 1 && d == 1) ov = 1'b1;
            else if (d > 1) nd = d - 1;
            else if (m > 1) begin nm = m - 1; nd = m_dim(y, nm); end
            else begin ny = y - 1; nm = 12; nd = 31; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic chk_date(input string tag, input int y, input int m, input int d);
        check($sformatf("%s year", tag), 32'(year), y);
        check($sformatf("%s month", tag), 32'(month), m);
        check($sformatf("%s day", tag), 32'(day), d);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, ew, ny, nm, nd;
        bit ov;
        load_year = 16'(v.y); load_month = 4'(v.m); load_day = 5'(v.d);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        if (v.err) begin
            check({tag, " load_err"}, 32'(load_err), 1);
            check({tag, " busy"}, 32'(busy), 0);
            chk_date({tag, " held"}, cur_y, cur_m, cur_d);
            check({tag, " week held"}, 32'(week), cur_w);
            step();
            check({tag, " load_err pulse"}, 32'(load_err), 0);
            return;
        end
        check({tag, " load_err"}, 32'(load_err), 0);
        check({tag, " busy"}, 32'(busy), 1);
        check({tag, " week_valid low"}, 32'(week_valid), 0);
        chk_date({tag, " loaded"}, v.y, v.m, v.d);
        wait_idle(n);
        check({tag, " latency"}, n, 38);
        ew = (v.wk >= 0) ? v.wk : m_wday(v.y, v.m, v.d);
        check({tag, " week"}, 32'(week), ew);
        check({tag, " week_valid"}, 32'(week_valid), 1);
        cur_y = v.y; cur_m = v.m; cur_d = v.d; cur_w = ew;
        if (v.tk != 0) begin
            tick_up = (v.tk == 1); tick_dn = (v.tk == 2);
            step();
            tick_up = 1'b0; tick_dn = 1'b0;
            chk_date({tag, " tick"}, v.ny, v.nm, v.nd);
            m_step(cur_y, cur_m, cur_d, v.tk, ny, nm, nd, ov);
            ew = (v.nwk >= 0) ? v.nwk : m_wday(ny, nm, nd);
            check({tag, " tick week"}, 32'(week), ew);
            check({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
            check({tag, " tick_drop"}, 32'(tick_drop), 0);
            step();
            check({tag, " ovf pulse"}, 32'(ovf), 0);
            cur_y = ny; cur_m = nm; cur_d = nd; cur_w = ew;
        end
    endtask

    initial begin
        vec_t v;
        int n, ny, nm, nd;
        bit ov;
        rst_n = 1'b0; load_valid = 1'b0; load_year = '0; load_month = '0; load_day = '0;
        tick_up = 1'b0; tick_dn = 1'b0;

        tbl[0]  = '{2024, 2, 28, 1'b0, 3, 1, 2024, 2, 29, 4, 1'b0};
        tbl[1]  = '{1900, 2, 28, 1'b0, 3, 1, 1900, 3, 1, 4, 1'b0};
        tbl[2]  = '{2023, 2, 29, 1'b1, -1, 0, 0, 0, 0, -1, 1'b0};
        tbl[3]  = '{1, 1, 1, 1'b0, 1, 2, 1, 1, 1, 1, 1'b1};
        tbl[4]  = '{2023, 12, 31, 1'b0, 0, 1, 2024, 1, 1, 1, 1'b0};
        tbl[5]  = '{2000, 3, 1, 1'b0, -1, 2, 2000, 2, 29, -1, 1'b0};
        tbl[6]  = '{65535, 12, 31, 1'b0, -1, 1, 65535, 12, 31, -1, 1'b1};
        tbl[7]  = '{2023, 4, 31, 1'b1, -1, 0, 0, 0, 0, -1, 1'b0};
        tbl[8]  = '{2023, 13, 1, 1'b1, -1, 0, 0, 0, 0, -1, 1'b0};
        tbl[9]  = '{0, 5, 5, 1'b1, -1, 0, 0, 0, 0, -1, 1'b0};
        tbl[10] = '{2023, 6, 0, 1'b1, -1, 0, 0, 0, 0, -1, 1'b0};
        tbl[11] = '{2100, 2, 28, 1'b0, -1, 1, 2100, 3, 1, -1, 1'b0};

        repeat (3) step();
        chk_date("reset", 2000, 1, 1);
        check("reset week", 32'(week), 0);
        check("reset week_valid", 32'(week_valid), 0);
        check("reset busy", 32'(busy), 1);
        check("reset load_ready", 32'(load_ready), 0);
        check("reset pulses", {29'd0, load_err, ovf, tick_drop}, 0);
        rst_n = 1'b1;
        step();
        check("edge0 busy", 32'(busy), 1);
        wait_idle(n);
        check("reset latency", n, 38);
        check("reset weekday", 32'(week), 6);
        check("reset week_valid", 32'(week_valid), 1);
        cur_y = 2000; cur_m = 1; cur_d = 1; cur_w = 6;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        run_vec(tbl[0], "leap2");
        tick_up = 1'b1; step(); tick_up = 1'b0;
        chk_date("leap2 second tick", 2024, 3, 1);
        check("leap2 second week", 32'(week), 5);
        cur_y = 2024; cur_m = 3; cur_d = 1; cur_w = 5;

        load_year = 16'd2010; load_month = 4'd7; load_day = 5'd4;
        load_valid = 1'b1; tick_up = 1'b1;
        step();
        load_valid = 1'b0; tick_up = 1'b0;
        check("collide tick_drop", 32'(tick_drop), 1);
        chk_date("collide load", 2010, 7, 4);
        check("collide busy", 32'(busy), 1);
        step();
        check("collide tick_drop pulse", 32'(tick_drop), 0);
        tick_up = 1'b1; step(); tick_up = 1'b0;
        check("busy tick_drop", 32'(tick_drop), 1);
        chk_date("busy tick", 2010, 7, 4);
        wait_idle(n);
        check("busy tick idle", 32'(busy), 0);
        check("busy tick week", 32'(week), m_wday(2010, 7, 4));
        cur_y = 2010; cur_m = 7; cur_d = 4; cur_w = m_wday(2010, 7, 4);
        tick_up = 1'b1; tick_dn = 1'b1; step(); tick_up = 1'b0; tick_dn = 1'b0;
        chk_date("both ticks", cur_y, cur_m, cur_d);
        check("both ticks week", 32'(week), cur_w);
        check("both ticks pulses", {30'd0, ovf, tick_drop}, 0);

        load_year = 16'd1999; load_month = 4'd5; load_day = 5'd5;
        load_valid = 1'b1; step(); load_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk_date("mid reset", 2000, 1, 1);
        check("mid reset busy", 32'(busy), 1);
        check("mid reset week_valid", 32'(week_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        wait_idle(n);
        check("mid reset latency", n, 38);
        check("mid reset weekday", 32'(week), 6);
        cur_y = 2000; cur_m = 1; cur_d = 1; cur_w = 6;

        for (int i = 0; i < 25; i++) begin
            v.err = 1'b0; v.wk = -1; v.nwk = -1;
            v.y = $urandom_range(1, 65535);
            v.m = $urandom_range(1, 12);
            v.d = $urandom_range(1, m_dim(v.y, v.m));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin v.y = 65535; v.m = 12; v.d = 31; end
                else begin v.y = 1; v.m = 1; v.d = 1; end
            end
            v.tk = $urandom_range(1, 2);
            if ($urandom_range(0, 4) == 0) begin
                v.err = 1'b1; v.tk = 0;
                if ($urandom_range(0, 1) == 0) v.m = 13; else v.d = m_dim(v.y, v.m) + 1;
            end
            m_step(v.y, v.m, v.d, v.tk, ny, nm, nd, ov);
            v.ny = ny; v.nm = nm; v.nd = nd; v.ovf = ov;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
